// File: rtl/mod_sub_pipe.sv
// Streaming modular subtractor res = (a - b) mod q, two register stages, 1 result/cycle.
// Latency 2 cycles; s_ready drops only when both stages are full and m_ready is low.
// Optional sticky operand range check enabled by defining MOD_SUB_RANGE_CHECK_EN.
module mod_sub_pipe #(
    parameter int WIDTH = 24,
    parameter int N     = 256,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] q,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] res,
    output logic             m_last,
    output logic             range_err
);

    logic             s1_vld_q;
    logic [WIDTH-1:0] s1_diff_q;
    logic             s1_borrow_q;
    logic             s1_last_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_d;

    logic             s2_vld_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             last_q;

    logic [WIDTH:0]   diff;
    logic             idx_last;
    logic             s2_load;
    logic             s1_adv;
    logic             in_xfer;

    assign diff     = {1'b0, a} - {1'b0, b};
    assign idx_last = (idx_q == CNT_W'(N - 1));
    assign idx_d    = idx_last ? '0 : idx_q + CNT_W'(1);

    assign s2_load  = !s2_vld_q || m_ready;
    assign s1_adv   = s1_vld_q && s2_load;
    assign s_ready  = !s1_vld_q || s1_adv;
    assign in_xfer  = s_valid && s_ready;

    // A borrow means a < b; adding q once lands back in [0, q-1] since a, b < q.
    assign res_d    = s1_borrow_q ? s1_diff_q + q : s1_diff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_diff_q   <= '0;
            s1_borrow_q <= 1'b0;
            s1_last_q   <= 1'b0;
            idx_q       <= '0;
        end else begin
            if (s_ready) begin
                s1_vld_q <= s_valid;
            end
            if (in_xfer) begin
                s1_diff_q   <= diff[WIDTH-1:0];
                s1_borrow_q <= diff[WIDTH];
                s1_last_q   <= idx_last;
                idx_q       <= idx_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            res_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_vld_q <= s1_vld_q;
            end
            if (s1_adv) begin
                res_q  <= res_d;
                last_q <= s1_last_q;
            end
        end
    end

    assign m_valid = s2_vld_q;
    assign res     = res_q;
    assign m_last  = last_q;

`ifdef MOD_SUB_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (in_xfer && ((a >= q) || (b >= q))) begin
            err_q <= 1'b1;
        end
    end

    assign range_err = err_q;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Randomized and directed bench for mod_sub_pipe with a queue-based reference model.
module tb_mod_sub_pipe;
    localparam int W  = 24;
    localparam int NN = 4;
`ifdef MOD_SUB_RANGE_CHECK_EN
    localparam logic EXP_RE = 1'b1;
`else
    localparam logic EXP_RE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid, s_ready, m_valid, m_ready, m_last, range_err;
    logic [W-1:0] a, b, q, res;

    mod_sub_pipe #(.WIDTH(W), .N(NN), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .a(a), .b(b), .q(q), .m_valid(m_valid), .m_ready(m_ready),
        .res(res), .m_last(m_last), .range_err(range_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] r; logic l; } exp_t;
    exp_t sb[$];
    int   mcnt;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [W-1:0] ref_sub(input longint x, input longint y, input longint m);
        return W'((((x - y) % m) + m) % m);
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
        s_valid = v; a = av; b = bv;
    endtask

    // Called at a falling edge; samples handshakes, updates the model, advances one cycle.
    task automatic tick(output bit ix, output bit ox, output bit mv,
                        output logic [W-1:0] r, output logic l);
        exp_t e;
        #1;
        ix = s_valid && s_ready; ox = m_valid && m_ready; mv = m_valid; r = res; l = m_last;
        if (ix) begin
            e.r = ref_sub(a, b, q); e.l = (mcnt == NN - 1);
            sb.push_back(e);
            mcnt = (mcnt + 1) % NN;
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic do_reset();
        s_valid = 1'b0; m_ready = 1'b1; rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        mcnt = 0; sb.delete();
    endtask

    task automatic test_reset();
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_mvalid: got %b want 0", m_valid); end
        tests++; if (res !== '0) begin fails++; $display("FAIL reset_res: got %0d want 0", res); end
        tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL reset_mlast: got %b want 0", m_last); end
        tests++; if (range_err !== 1'b0) begin fails++; $display("FAIL reset_rerr: got %b want 0", range_err); end
        @(negedge clk); rst = 1'b0; #1;
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_sready: got %b want 1", s_ready); end
        @(negedge clk); mcnt = 0; sb.delete();
    endtask

    task automatic test_basic();
        bit ix, ox, mv; logic [W-1:0] r; logic l;
        do_reset(); q = 8380417; m_ready = 1'b1;
        drive(1, 5, 3); tick(ix, ox, mv, r, l); drive(0, 0, 0);
        tests++; if (ix !== 1'b1) begin fails++; $display("FAIL basic_accept: got %b want 1", ix); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL basic_lat1: m_valid got %b want 0", m_valid); end
        tick(ix, ox, mv, r, l);
        tests++; if (m_valid !== 1'b1 || res !== 24'd2) begin fails++; $display("FAIL basic_5m3: valid %b res %0d want 1/2", m_valid, res); end
        drive(1, 3, 5); tick(ix, ox, mv, r, l); drive(0, 0, 0); tick(ix, ox, mv, r, l);
        tests++; if (m_valid !== 1'b1 || res !== 24'd8380415) begin fails++; $display("FAIL basic_3m5: valid %b res %0d want 1/8380415", m_valid, res); end
        tick(ix, ox, mv, r, l);
    endtask

    task automatic test_boundary();
        bit ix, ox, mv; logic [W-1:0] r; logic l;
        logic [W-1:0] av[3] = '{24'd1234, 24'd0, 24'd8380416};
        logic [W-1:0] bv[3] = '{24'd1234, 24'd8380416, 24'd0};
        logic [W-1:0] ev[3] = '{24'd0, 24'd1, 24'd8380416};
        logic [W-1:0] got[$];
        do_reset(); q = 8380417;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1, av[i], bv[i]); else drive(0, 0, 0);
            tick(ix, ox, mv, r, l);
            if (ox) got.push_back(r);
        end
        tests++; if (got.size() != 3) begin fails++; $display("FAIL bound_count: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            tests++; if (got[i] !== ev[i]) begin fails++; $display("FAIL bound_%0d: got %0d want %0d", i, got[i], ev[i]); end
        end
    endtask

    task automatic test_stream();
        bit ix, ox, mv; logic [W-1:0] r; logic l;
        logic [W-1:0] av[5] = '{24'd1, 24'd2, 24'd0, 24'd16, 24'd5};
        logic [W-1:0] bv[5] = '{24'd2, 24'd1, 24'd16, 24'd16, 24'd3};
        logic [W-1:0] ev[5] = '{24'd16, 24'd1, 24'd1, 24'd0, 24'd2};
        logic         el[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] gr[$]; logic gl[$]; int gc[$]; int acc = 0;
        do_reset(); q = 17;
        for (int i = 0; i < 9; i++) begin
            if (i < 5) drive(1, av[i], bv[i]); else drive(0, 0, 0);
            tick(ix, ox, mv, r, l);
            if (ix) acc++;
            if (ox) begin gr.push_back(r); gl.push_back(l); gc.push_back(i); end
        end
        tests++; if (acc != 5 || gr.size() != 5) begin fails++; $display("FAIL stream_count: acc %0d out %0d want 5/5", acc, gr.size()); end
        for (int i = 0; i < 5 && i < gr.size(); i++) begin
            tests++;
            if (gr[i] !== ev[i] || gl[i] !== el[i] || gc[i] != gc[0] + i) begin
                fails++; $display("FAIL stream_%0d: res %0d last %b cyc %0d want %0d %b %0d",
                                  i, gr[i], gl[i], gc[i], ev[i], el[i], gc[0] + i);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ix, ox, mv; logic [W-1:0] r, hr; logic l, hl; bit seen = 0;
        int acc = 0, outs = 0, sent;
        exp_t e;
        do_reset(); q = 17; m_ready = 1'b0;
        drive(1, W'($urandom_range(0, 16)), W'($urandom_range(0, 16)));
        for (int i = 0; i < 6; i++) begin
            tick(ix, ox, mv, r, l);
            if (ix) begin acc++; drive(1, W'($urandom_range(0, 16)), W'($urandom_range(0, 16))); end
            if (mv && seen) begin
                tests++; if (r !== hr || l !== hl) begin fails++; $display("FAIL bp_hold: res %0d last %b want %0d %b", r, l, hr, hl); end
            end
            if (mv && !seen) begin seen = 1; hr = r; hl = l; end
        end
        #1;
        tests++; if (acc != 2 || s_ready !== 1'b0) begin fails++; $display("FAIL bp_stall: acc %0d s_ready %b want 2 0", acc, s_ready); end
        m_ready = 1'b1; sent = acc;
        for (int i = 0; i < 20; i++) begin
            if (sent >= 6) drive(0, 0, 0);
            tick(ix, ox, mv, r, l);
            if (ix) begin sent++; drive(1, W'($urandom_range(0, 16)), W'($urandom_range(0, 16))); end
            if (ox) begin
                outs++; tests++;
                if (sb.size() == 0) begin fails++; $display("FAIL bp_extra: res %0d with empty model", r); end
                else begin
                    e = sb.pop_front();
                    if (r !== e.r || l !== e.l) begin fails++; $display("FAIL bp_order: res %0d last %b want %0d %b", r, l, e.r, e.l); end
                end
            end
        end
        tests++; if (outs != 6 || sb.size() != 0) begin fails++; $display("FAIL bp_total: out %0d left %0d want 6 0", outs, sb.size()); end
    endtask

    task automatic test_reset_mid();
        bit ix, ox, mv; logic [W-1:0] r; logic l; int acc = 0;
        logic gl[$];
        do_reset(); q = 17; m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1, 24'd9, 24'd4); else drive(0, 0, 0);
            tick(ix, ox, mv, r, l);
            if (ix) acc++;
        end
        tests++; if (acc != 2 || m_valid !== 1'b1) begin fails++; $display("FAIL mid_pre: acc %0d m_valid %b want 2 1", acc, m_valid); end
        #2 rst = 1'b1; #1;
        tests++; if (m_valid !== 1'b0 || range_err !== 1'b0) begin fails++; $display("FAIL mid_async: m_valid %b range_err %b want 0 0", m_valid, range_err); end
        #1 rst = 1'b0;
        @(negedge clk); mcnt = 0; sb.delete(); m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1, W'(i), 24'd1); else drive(0, 0, 0);
            tick(ix, ox, mv, r, l);
            if (ox) gl.push_back(l);
        end
        tests++;
        if (gl.size() != 4) begin fails++; $display("FAIL mid_count: got %0d want 4", gl.size()); end
        else if (gl[0] !== 1'b0 || gl[1] !== 1'b0 || gl[2] !== 1'b0 || gl[3] !== 1'b1) begin
            fails++; $display("FAIL mid_last: got %b%b%b%b want 0001", gl[0], gl[1], gl[2], gl[3]);
        end
    endtask

    task automatic test_range();
        bit ix, ox, mv; logic [W-1:0] r; logic l;
        do_reset(); q = 17;
        drive(1, 24'd3, 24'd16); tick(ix, ox, mv, r, l);
        tests++; if (range_err !== 1'b0) begin fails++; $display("FAIL range_legal: got %b want 0", range_err); end
        drive(1, 24'd17, 24'd0); tick(ix, ox, mv, r, l); drive(0, 0, 0);
        tests++; if (range_err !== EXP_RE) begin fails++; $display("FAIL range_set: got %b want %b", range_err, EXP_RE); end
        for (int i = 0; i < 3; i++) tick(ix, ox, mv, r, l);
        tests++; if (range_err !== EXP_RE) begin fails++; $display("FAIL range_sticky: got %b want %b", range_err, EXP_RE); end
    endtask

    task automatic test_random();
        bit ix, ox, mv; logic [W-1:0] r; logic l; exp_t e;
        logic [W-1:0] qs[3] = '{24'd2, 24'd8380417, 24'hFFFFFF};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            q = (k < 3) ? qs[k] : W'($urandom_range(2, 24'hFFFFFF));
            for (int i = 0; i < 300; i++) begin
                if (i < 290) begin
                    drive(1'($urandom_range(0, 1)), W'($urandom_range(0, q - 1)), W'($urandom_range(0, q - 1)));
                    m_ready = 1'($urandom_range(0, 3) != 0);
                end else begin
                    drive(0, 0, 0); m_ready = 1'b1;
                end
                tick(ix, ox, mv, r, l);
                if (ox) begin
                    tests++;
                    if (sb.size() == 0) begin fails++; $display("FAIL rand_extra: res %0d q %0d", r, q); end
                    else begin
                        e = sb.pop_front();
                        if (r !== e.r || l !== e.l) begin fails++; $display("FAIL rand_cmp: res %0d last %b want %0d %b q %0d", r, l, e.r, e.l, q); end
                    end
                end
            end
            tests++; if (sb.size() != 0) begin fails++; $display("FAIL rand_drain: %0d results missing", sb.size()); end
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; a = '0; b = '0; q = 24'd17; mcnt = 0;
        #3;
        test_reset();
        test_basic();
        test_boundary();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mod_sub_pipe.md
Name: mod_sub_pipe

Overview:
- Streaming modular subtractor: res = (a - b) mod q, one coefficient per cycle, 2-stage pipeline.
- Valid/ready handshake on both sides.
- Counts coefficients and tags the last one of each N-element vector.
- Sits in the keygen datapath as the inverse-direction counterpart of the modular adder, for polynomial subtraction and NTT butterfly-difference paths.

Parameters:
- WIDTH, 24, coefficient and modulus width in bits.
- N, 256, coefficients per vector; m_last marks every N-th output.
- CNT_W, 8, index counter width; must satisfy 2^CNT_W >= N.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  input operand pair valid.
- s_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  minuend; must be < q.
- b  input  WIDTH  subtrahend; must be < q.
- q  input  WIDTH  modulus; 2 <= q < 2^WIDTH; held stable while any element is in flight.
- m_valid  output  1  result valid.
- m_ready  input  1  downstream accepts result.
- res  output  WIDTH  (a - b) mod q, in range [0, q-1].
- m_last  output  1  result is element N-1 of the current vector.
- range_err  output  1  sticky operand range error; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high):
  - Both stage valid bits = 0; m_valid = 0; res = 0; m_last = 0; range_err = 0; index counter = 0.
  - s_ready = 1 the first cycle after rst deasserts.
- Transfers:
  - Input transfer: s_valid && s_ready at the clock edge.
  - Output transfer: m_valid && m_ready at the clock edge.
- Stage 1, on input transfer:
  - diff = {1'b0,a} - {1'b0,b}, computed WIDTH+1 bits wide; borrow = diff[WIDTH].
  - Register diff[WIDTH-1:0], borrow, and last = (idx == N-1).
  - idx increments, wrapping from N-1 to 0.
- Stage 2:
  - res = borrow ? diff + q (modulo 2^WIDTH) : diff.
  - No second reduction is needed, since a, b < q.
- Latency: 2 cycles from input transfer to m_valid when there is no backpressure. Throughput is 1 result per cycle.
- Pipeline advance:
  - Stage 2 loads when it is empty or its output transfer happens in the same cycle.
  - Stage 1 loads when it is empty or it is advancing into stage 2.
  - s_ready = !s1_valid || s1_advance, combinational from m_ready. No bubbles under continuous flow.
- Backpressure:
  - While m_ready = 0 and both stages are full, s_ready = 0.
  - res and m_last hold stable while m_valid && !m_ready.
- Simultaneous input and output transfer in the same cycle: both occur; occupancy is unchanged.
- Boundaries:
  - a == b gives 0.
  - a = 0, b = q-1 gives 1.
  - a = q-1, b = 0 gives q-1.
- Changing q while any element is in flight is illegal; the result is undefined, with no hang.
- Reset mid-vector: all in-flight data is discarded and idx returns to 0. The next accepted element is element 0.

Optional Feature:
- Macro: MOD_SUB_RANGE_CHECK_EN.
- Defined:
  - On each input transfer, if a >= q or b >= q, range_err is set the next cycle and stays 1 until rst.
  - The element is still processed. Its result is unspecified but lies in WIDTH bits.
- Undefined: range_err is tied to 0 and no comparators are synthesized.
- All other behaviour is identical with or without the macro.

Test Plan:
- Basic, q=8380417:
  - a=5, b=3 -> res=2, m_valid 2 cycles after acceptance.
  - a=3, b=5 -> res=8380415.
- Boundaries, q=8380417:
  - a=b=1234 -> 0.
  - a=0, b=8380416 -> 1.
  - a=8380416, b=0 -> 8380416.
- Streaming, N=4, q=17, m_ready=1, back-to-back inputs (a,b) = (1,2), (2,1), (0,16), (16,16):
  - Results 16, 1, 1, 0 on consecutive cycles.
  - m_last=1 only on the 4th result.
  - The 5th input starts a new vector (m_last=0 on it).
- Backpressure: hold m_ready=0 with s_valid=1.
  - Exactly 2 elements are accepted, then s_ready=0; res/m_last stay stable.
  - On release, results emerge in order with no loss or duplication.
- Reset mid-vector: after 2 of N=4 elements are accepted, pulse rst asynchronously between edges.
  - m_valid=0 and range_err=0 immediately.
  - After reset, m_last is asserted on the 4th new element, not the 2nd.
- With MOD_SUB_RANGE_CHECK_EN, q=17:
  - a=17, b=0 -> range_err=1 the next cycle and it stays set.
  - Without the macro, the same stimulus leaves range_err=0.
